// File: rtl/alu_arbiter_if.sv
// One requester's link to alu_arbiter: operation request plus registered result return.
// Both directions use valid/ready; the arbiter side is the slave modport.
interface alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between two requesters (round-robin or fixed priority); ALU_ARB_ERR_EN adds rsp_err.
// Latency: request accepted in IDLE, result valid two cycles later; one operation in flight at a time.
// Backpressure: result held until rsp_ready; no new request is granted until the result handshake completes.
module alu_arbiter #(
  parameter bit          RR_EN     = 1'b1,
  parameter logic [31:0] ILLEGAL_C = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave req0_if,
  alu_arbiter_if.slave req1_if
`ifdef ALU_ARB_ERR_EN
  ,
  output logic         rsp_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } alu_req_t;

  state_e      state_q, state_d;
  alu_req_t    op_q, op_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] result_q, result_d;
  logic [31:0] alu_c;
  logic        arb_vld;
  logic        arb_id;
  logic        rsp_rdy_sel;
`ifdef ALU_ARB_ERR_EN
  logic        rsp_err_q, rsp_err_d;
`endif

  // On a conflict, round-robin grants whoever was not served last.
  always_comb begin
    arb_vld = req0_if.req_valid | req1_if.req_valid;
    arb_id  = 1'b0;
    if (req0_if.req_valid && req1_if.req_valid) begin
      arb_id = RR_EN ? ~last_grant_q : 1'b0;
    end else begin
      arb_id = req1_if.req_valid;
    end
  end

  assign rsp_rdy_sel = gnt_q ? req1_if.rsp_ready : req0_if.rsp_ready;

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    gnt_d             = gnt_q;
    last_grant_d      = last_grant_q;
    result_d          = result_q;
    req0_if.req_ready = 1'b0;
    req1_if.req_ready = 1'b0;
    req0_if.rsp_valid = 1'b0;
    req1_if.rsp_valid = 1'b0;
`ifdef ALU_ARB_ERR_EN
    rsp_err_d         = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req0_if.req_ready = arb_vld & ~arb_id;
        req1_if.req_ready = arb_vld & arb_id;
`ifdef ALU_ARB_ERR_EN
        rsp_err_d         = 1'b0;
`endif
        if (arb_vld) begin
          if (arb_id) begin
            op_d = '{a: req1_if.req_a, b: req1_if.req_b, op: req1_if.req_op};
          end else begin
            op_d = '{a: req0_if.req_a, b: req0_if.req_b, op: req0_if.req_op};
          end
          gnt_d   = arb_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_c;
`ifdef ALU_ARB_ERR_EN
        rsp_err_d = (op_q.op[2:1] == 2'b11);
`endif
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        req0_if.rsp_valid = ~gnt_q;
        req1_if.rsp_valid = gnt_q;
        if (rsp_rdy_sel) begin
          last_grant_d = gnt_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req0_if.rsp_data = result_q;
  assign req1_if.rsp_data = result_q;

  // Reset drops any in-flight operation; last_grant=1 lets req0 win the first conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

`ifdef ALU_ARB_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`endif

  alu32 #(
    .ILLEGAL_C(ILLEGAL_C)
  ) u_alu (
    .a (op_q.a),
    .b (op_q.b),
    .op(op_q.op),
    .c (alu_c)
  );

endmodule

// Combinational 32-bit ALU; shifts take the full B as amount, so B>=32 shifts everything out.
module alu32 #(
  parameter logic [31:0] ILLEGAL_C = 32'h0
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] c
);

  logic big_shift;

  assign big_shift = |b[31:5];

  always_comb begin
    c = ILLEGAL_C;
    case (op)
      3'b000:  c = a + b;
      3'b001:  c = a - b;
      3'b010:  c = a & b;
      3'b011:  c = a | b;
      3'b100:  c = big_shift ? 32'h0 : (a >> b[4:0]);
      3'b101:  c = big_shift ? {32{a[31]}} : $unsigned($signed(a) >>> b[4:0]);
      default: c = ILLEGAL_C;
    endcase
  end

endmodule
